// File: rtl/mem_wb_pkg.sv
// Shared types for the MEM/WB pipeline boundary: control bundle, payload layout
// and the helper that suppresses architectural-write controls on empty slots.
package mem_wb_pkg;

    localparam int CTRL_W     = 5;
    localparam int DATA_W_DEF = 64;
    localparam int REG_W_DEF  = 5;

    typedef struct packed {
        logic memtoreg;
        logic regwrite;
        logic r_memtoreg;
        logic jmp_and_link;
        logic lohi_write;
    } mem_wb_ctrl_t;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] mem_data;
        logic [DATA_W_DEF-1:0] alu_data;
        logic [REG_W_DEF-1:0]  dst_reg;
        logic [REG_W_DEF-1:0]  fp_dst_reg;
        mem_wb_ctrl_t          ctrl;
    } mem_wb_payload_t;

    // Controls that write architectural state must never leak from an empty slot.
    function automatic mem_wb_ctrl_t gate_ctrl(input mem_wb_ctrl_t c, input logic v);
        mem_wb_ctrl_t g;
        g              = c;
        g.regwrite     = c.regwrite & v;
        g.jmp_and_link = c.jmp_and_link & v;
        g.lohi_write   = c.lohi_write & v;
        return g;
    endfunction

endpackage

// File: rtl/pipe_skid_slot.sv
// One pipeline storage slot: a payload register plus valid bit with load/clear.
// clear drops the valid bit only; the payload keeps its stale contents.
module pipe_skid_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             set_valid,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    output logic             valid,
    output logic [WIDTH-1:0] q
);

    logic             valid_reg;
    logic [WIDTH-1:0] q_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_reg <= 1'b0;
            q_reg     <= '0;
        end else if (clear) begin
            valid_reg <= 1'b0;
        end else if (load) begin
            valid_reg <= set_valid;
            if (set_valid) begin
                q_reg <= d;
            end
        end
    end

    assign valid = valid_reg;
    assign q     = q_reg;

endmodule

// File: rtl/mem_wb_pipe_reg.sv
// MEM/WB boundary with valid/ready handshake, one-entry skid buffer, flush
// and a saturating count of cycles the writeback stage stalled.
module mem_wb_pipe_reg
    import mem_wb_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_mem_data,
    input  logic [DATA_W-1:0] in_alu_data,
    input  logic [REG_W-1:0]  in_dst_reg,
    input  logic [REG_W-1:0]  in_fp_dst_reg,
    input  mem_wb_ctrl_t      in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_mem_data,
    output logic [DATA_W-1:0] out_alu_data,
    output logic [REG_W-1:0]  out_dst_reg,
    output logic [REG_W-1:0]  out_fp_dst_reg,
    output mem_wb_ctrl_t      out_ctrl,
    input  logic              clr_stats,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int PAY_W = 2*DATA_W + 2*REG_W + CTRL_W;
    localparam int MAIN  = 0;
    localparam int SKID  = 1;

    logic [PAY_W-1:0] in_payload;
    logic [PAY_W-1:0] slot_d     [2];
    logic [PAY_W-1:0] slot_q     [2];
    logic             slot_load  [2];
    logic             slot_set   [2];
    logic             slot_clear [2];
    logic             slot_valid [2];

    logic         main_valid;
    logic         skid_valid;
    logic         accept;
    logic         drain;
    logic         main_load;
    mem_wb_ctrl_t main_ctrl;

    logic [CNT_W-1:0] stall_cnt_reg;
    logic [CNT_W-1:0] stall_cnt_next;

    assign in_payload = {in_mem_data, in_alu_data, in_dst_reg, in_fp_dst_reg, in_ctrl};

    // Slot 0 drives the outputs, slot 1 catches the extra beat while WB stalls.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            pipe_skid_slot #(
                .WIDTH(PAY_W)
            ) u_slot (
                .clk      (clk),
                .rst_n    (rst_n),
                .load     (slot_load[gi]),
                .set_valid(slot_set[gi]),
                .clear    (slot_clear[gi]),
                .d        (slot_d[gi]),
                .valid    (slot_valid[gi]),
                .q        (slot_q[gi])
            );
        end
    endgenerate

    always_comb begin
        main_valid = slot_valid[MAIN];
        skid_valid = slot_valid[SKID];
        accept     = in_valid && !skid_valid && !flush;
        drain      = main_valid && out_ready;
        main_load  = !main_valid || drain;

        slot_load[MAIN]  = main_load;
        slot_set[MAIN]   = skid_valid || accept;
        slot_d[MAIN]     = skid_valid ? slot_q[SKID] : in_payload;
        slot_clear[MAIN] = flush;

        // The skid empties whenever main takes its entry; it is never
        // refilled in that same cycle because in_ready was low.
        slot_load[SKID]  = accept && main_valid && !drain;
        slot_set[SKID]   = 1'b1;
        slot_d[SKID]     = in_payload;
        slot_clear[SKID] = flush || (main_load && skid_valid);
    end

    assign {out_mem_data, out_alu_data, out_dst_reg, out_fp_dst_reg, main_ctrl} = slot_q[MAIN];
    assign out_ctrl  = gate_ctrl(main_ctrl, main_valid);
    assign out_valid = main_valid;
    assign in_ready  = !skid_valid;

    always_comb begin
        stall_cnt_next = stall_cnt_reg;
        if (clr_stats) begin
            stall_cnt_next = '0;
        end else if (main_valid && !out_ready && (stall_cnt_reg != {CNT_W{1'b1}})) begin
            stall_cnt_next = stall_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_reg <= '0;
        end else begin
            stall_cnt_reg <= stall_cnt_next;
        end
    end

    assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// Scoreboard bench for mem_wb_pipe_reg: directed handshake/flush/reset/saturation
// scenarios followed by a long random run against a reference queue.
module tb_mem_wb_pipe_reg;
    import mem_wb_pkg::*;

    localparam int DATA_W  = 64;
    localparam int REG_W   = 5;
    localparam int CNT_W   = 4;
    localparam int PAY_W   = 2*DATA_W + 2*REG_W + CTRL_W;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef logic [PAY_W-1:0] pay_t;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_mem_data;
    logic [DATA_W-1:0] in_alu_data;
    logic [REG_W-1:0]  in_dst_reg;
    logic [REG_W-1:0]  in_fp_dst_reg;
    mem_wb_ctrl_t      in_ctrl;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_mem_data;
    logic [DATA_W-1:0] out_alu_data;
    logic [REG_W-1:0]  out_dst_reg;
    logic [REG_W-1:0]  out_fp_dst_reg;
    mem_wb_ctrl_t      out_ctrl;
    logic              clr_stats;
    logic [CNT_W-1:0]  stall_cnt;

    pay_t exp_q[$];
    int   model_cnt;
    int   checks;
    int   errors;
    bit   verbose;

    mem_wb_pipe_reg #(
        .DATA_W(DATA_W),
        .REG_W (REG_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_mem_data   (in_mem_data),
        .in_alu_data   (in_alu_data),
        .in_dst_reg    (in_dst_reg),
        .in_fp_dst_reg (in_fp_dst_reg),
        .in_ctrl       (in_ctrl),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_mem_data  (out_mem_data),
        .out_alu_data  (out_alu_data),
        .out_dst_reg   (out_dst_reg),
        .out_fp_dst_reg(out_fp_dst_reg),
        .out_ctrl      (out_ctrl),
        .clr_stats     (clr_stats),
        .stall_cnt     (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [191:0] got, input logic [191:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic pay_t mk(input logic [63:0] alu, input logic [4:0] dst, input logic [4:0] ctrl);
        return {64'hA5A5_0000_0000_0000 ^ alu, alu, dst, dst ^ 5'd3, ctrl};
    endfunction

    function automatic pay_t rnd_pay();
        pay_t p;
        for (int i = 0; i < PAY_W; i++) p[i] = ($urandom & 1) != 0;
        return p;
    endfunction

    // Checks the current (registered) outputs, advances the model, then crosses one edge.
    task automatic cycle();
        pay_t got;
        pay_t in_pay;
        bit   acc;
        bit   drn;
        got    = {out_mem_data, out_alu_data, out_dst_reg, out_fp_dst_reg, out_ctrl};
        in_pay = {in_mem_data, in_alu_data, in_dst_reg, in_fp_dst_reg, in_ctrl};
        check_val("out_valid", out_valid, exp_q.size() > 0);
        check_val("in_ready", in_ready, exp_q.size() < 2);
        check_val("stall_cnt", stall_cnt, model_cnt);
        if (exp_q.size() > 0)
            check_val("payload", got, exp_q[0]);
        else
            check_val("gated_ctrl", {out_ctrl.regwrite, out_ctrl.jmp_and_link, out_ctrl.lohi_write}, 3'b000);

        if (!rst_n) begin
            exp_q.delete();
            model_cnt = 0;
        end else begin
            if (clr_stats) model_cnt = 0;
            else if (exp_q.size() > 0 && !out_ready && model_cnt < CNT_MAX) model_cnt++;
            drn = (exp_q.size() > 0) && out_ready;
            acc = in_valid && (exp_q.size() < 2) && !flush;
            if (drn) begin
                if (verbose) $display("wb: alu=%0h dst=%0d ctrl=%b", out_alu_data, out_dst_reg, out_ctrl);
                void'(exp_q.pop_front());
            end
            if (acc) exp_q.push_back(in_pay);
            if (flush) exp_q.delete();
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step(input logic v, input pay_t p, input logic fl, input logic ordy,
                        input logic clr, input logic rn);
        in_valid = v;
        {in_mem_data, in_alu_data, in_dst_reg, in_fp_dst_reg, in_ctrl} = p;
        flush     = fl;
        out_ready = ordy;
        clr_stats = clr;
        rst_n     = rn;
        cycle();
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, "_mem"}, out_mem_data, 0);
        check_val({tag, "_alu"}, out_alu_data, 0);
        check_val({tag, "_dst"}, out_dst_reg, 0);
        check_val({tag, "_fp"}, out_fp_dst_reg, 0);
        check_val({tag, "_ctrl"}, out_ctrl, 0);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        model_cnt = 0;
        verbose   = 1'b1;
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        {in_mem_data, in_alu_data, in_dst_reg, in_fp_dst_reg, in_ctrl} = mk(64'hDEAD, 5'd9, 5'b11111);
        flush     = 1'b0;
        out_ready = 1'b1;
        clr_stats = 1'b0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        check_val("reset_valid", out_valid, 1'b0);
        check_val("reset_ready", in_ready, 1'b1);
        check_val("reset_cnt", stall_cnt, 0);

        // Single transfer then a back-to-back stream of 8.
        step(1, mk(64'h1234, 5'd7, 5'b01000), 0, 1, 0, 1);
        for (int i = 0; i < 8; i++) step(1, mk(64'h100 + 64'(i), 5'(i), 5'b01011), 0, 1, 0, 1);
        repeat (2) step(0, '0, 0, 1, 0, 1);

        // A into main, B into skid while WB stalls, then release.
        step(1, mk(64'hAAAA, 5'd1, 5'b11000), 0, 0, 0, 1);
        step(1, mk(64'hBBBB, 5'd2, 5'b01100), 0, 0, 0, 1);
        step(1, mk(64'hBAD0, 5'd3, 5'b01000), 0, 0, 0, 1);
        step(0, '0, 0, 0, 0, 1);
        repeat (3) step(0, '0, 0, 1, 0, 1);

        // Flush in FULL state with C offered: everything disappears.
        step(1, mk(64'hA1, 5'd4, 5'b01001), 0, 0, 0, 1);
        step(1, mk(64'hB1, 5'd5, 5'b01010), 0, 0, 0, 1);
        step(1, mk(64'hCCCC, 5'd6, 5'b01111), 1, 0, 0, 1);
        repeat (2) step(0, '0, 0, 1, 0, 1);

        // Saturation of the stall counter, then clear while still stalling.
        step(1, mk(64'hD0, 5'd8, 5'b01000), 0, 0, 0, 1);
        repeat (20) step(0, '0, 0, 0, 0, 1);
        check_val("stall_sat", stall_cnt, CNT_MAX);
        step(0, '0, 0, 0, 1, 1);
        check_val("stall_clr", stall_cnt, 0);
        repeat (2) step(0, '0, 0, 0, 0, 1);
        repeat (2) step(0, '0, 0, 1, 0, 1);

        // Reset while FULL with a new input offered.
        step(1, mk(64'hE1, 5'd10, 5'b11111), 0, 0, 0, 1);
        step(1, mk(64'hE2, 5'd11, 5'b11111), 0, 0, 0, 1);
        step(1, mk(64'hE3, 5'd12, 5'b11111), 0, 0, 0, 0);
        check_zero("midrst");
        repeat (2) step(0, '0, 0, 1, 0, 1);

        // Random traffic against the reference queue.
        verbose = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            step(($urandom % 2) != 0, rnd_pay(), ($urandom % 20) == 0,
                 ($urandom % 10) < 7, ($urandom % 50) == 0, 1'b1);
        end
        repeat (3) step(0, '0, 0, 1, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_wb_pipe_reg.md
# mem_wb_pipe_reg

Parametrised MEM/WB pipeline boundary with valid/ready flow control, a one-entry skid buffer, synchronous flush and a saturating back-pressure counter. Sits between the memory stage and the writeback/register-file logic and replaces the free-running, always-load MEM/WB latch. Writeback can now stall without losing an in-flight instruction. Squashed instructions never reach architectural state.

## Interface
Parameters:
- DATA_W, 64, width of memory-data and ALU-result paths
- REG_W, 5, width of integer and FP destination register indices
- CNT_W, 16, width of stall counter

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  MEM stage presents an instruction
- in_ready  out  1  boundary can accept; equals !skid_valid
- in_mem_data  in  DATA_W  load data from memory
- in_alu_data  in  DATA_W  ALU/EXE result
- in_dst_reg  in  REG_W  integer destination
- in_fp_dst_reg  in  REG_W  FP destination
- in_ctrl  in  mem_wb_ctrl_t (5)  {memtoreg, regwrite, r_memtoreg, jmp_and_link, lohi_write}
- flush  in  1  squash everything held and offered this cycle
- out_valid  out  1  WB stage holds a valid instruction
- out_ready  in  1  WB stage consumes this cycle
- out_mem_data, out_alu_data  out  DATA_W  registered data
- out_dst_reg, out_fp_dst_reg  out  REG_W  registered destinations
- out_ctrl  out  mem_wb_ctrl_t  registered control, gated (see Operation)
- clr_stats  in  1  clear stall counter
- stall_cnt  out  CNT_W  saturating count of stalled cycles

## Operation
- Storage: main entry (drives outputs) + skid entry; each has a valid bit and a full payload.
- Accept: in_valid && in_ready && !flush && rst_n.
- Drain: out_valid && out_ready.
- Main loads when !out_valid or drain. Source is skid if skid_valid, else the input if accepted, else main goes empty.
- Skid loads when an input is accepted while main is occupied and not draining. This is possible only while skid is empty, so no overflow.
- Simultaneous drain + accept with skid full cannot occur, because in_ready=0.
- States, by {main_valid, skid_valid}:
  - EMPTY {0,0} → ONE on accept.
  - ONE {1,0} → EMPTY on drain without accept; → FULL on accept without drain; stays ONE on drain + accept.
  - FULL {1,1} → ONE on drain.
- Flush (priority over everything): next cycle both valids = 0. The input offered in the flush cycle is dropped. A drain in the flush cycle still counts as consumed. Payload registers may retain stale data.
- Gating: out_ctrl.regwrite, out_ctrl.lohi_write and out_ctrl.jmp_and_link are forced 0 whenever out_valid=0. out_ctrl.memtoreg and out_ctrl.r_memtoreg pass through raw.
- stall_cnt increments by 1 each cycle with out_valid && !out_ready. It saturates at 2^CNT_W−1 with no wrap. clr_stats zeroes it and wins over a same-cycle increment. flush does not affect it.

## Timing
- Reset (rst_n=0 at a clk edge):
  - main_valid and skid_valid = 0.
  - All payload registers, out_ctrl and stall_cnt = 0.
  - in_ready = 1 after reset (skid empty); no transfer is honoured while rst_n=0.
- Latency: accepted input appears on outputs 1 cycle later when main is free. With main occupied, latency is 1 + stall cycles.
- Throughput: 1 instruction/cycle with out_ready held 1.
- in_ready is purely registered state (no combinational path from out_ready). Outputs are registered.
- Reset asserted mid-operation discards both entries at the next edge.

## Structure
- Package mem_wb_pkg:
  - typedef mem_wb_ctrl_t (packed struct, 5 bits, field order as listed).
  - Localparam CTRL_W=5.
  - Typedef for the full payload struct (data, dst, fp_dst, ctrl) parametrised via DATA_W/REG_W defaults.
- One natural sub-module: pipe_skid_slot. It holds a single payload + valid with load/clear controls and is instantiated twice (main, skid). The counter stays inline.

## Test plan
- Reset, then in_valid=1 with alu_data=0x1234, dst=7, regwrite=1, out_ready=1 → next cycle out_valid=1, out_alu_data=0x1234, out_dst_reg=7, out_ctrl.regwrite=1; continuous stream of 8 → 8 outputs on consecutive cycles, in order.
- Hold out_ready=0, offer A then B → A in main, B in skid, in_ready=0 from the following cycle. Raise out_ready → A then B on consecutive cycles, in_ready returns 1, stall_cnt counts the stalled cycles exactly.
- FULL state, assert flush with in_valid=1 carrying C → next cycle out_valid=0, out_ctrl.regwrite=0, in_ready=1; C never appears.
- CNT_W=4, out_valid=1, out_ready=0 for 20 cycles → stall_cnt stops at 15. Pulse clr_stats while still stalling → 0 the next cycle.
- Drive rst_n=0 for one edge while FULL → all outputs 0 and out_valid=0, stall_cnt=0. in_valid during reset is ignored.
- Random in_valid/out_ready/flush for 10k cycles against a reference queue model → no loss, duplication or reordering among non-flushed items, and gated controls are always 0 when out_valid=0.
